// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_pkg
// Description : Shared definitions for the neuron accelerator datapath:
//               MAC state encoding, default Q-format widths and the
//               accumulator width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

  localparam int c_def_int_width  = 16;
  localparam int c_def_frac_width = 16;
  localparam int c_def_n_inputs   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_BIAS  = 2'd3
  } mac_state_e;

  // Wide enough for N full-precision products (after the fractional shift)
  // plus a bias, with one spare bit so the running sum never wraps.
  function automatic int acc_width(input int int_w, input int frac_w, input int n_inputs);
    return 2 * int_w + frac_w + $clog2(n_inputs) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_if
// Description : Beat-in / result-out bundle between a producer, the MAC and
//               the downstream activation stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] weight_in;
  logic [DATA_W-1:0] bias;
  logic              out_valid;
  logic [DATA_W-1:0] sum_out;
  logic              sat;

  modport master (
    output in_valid, data_in, weight_in, bias,
    input  in_ready, out_valid, sum_out, sat
  );

  modport slave (
    input  in_valid, data_in, weight_in, bias,
    output in_ready, out_valid, sum_out, sat
  );

endinterface
`default_nettype wire

// File: rtl/fx_saturate.sv
`default_nettype none
// ============================================================================
// Module      : fx_saturate
// Description : Clamps a wide signed fixed-point value into the signed
//               INT_WIDTH.FRAC_WIDTH format and flags when clamping happened.
// Revision    : 1.0 - initial release
// ============================================================================
module fx_saturate
  import accel_pkg::*;
#(
  parameter int IN_W       = acc_width(c_def_int_width, c_def_frac_width, c_def_n_inputs),
  parameter int INT_WIDTH  = c_def_int_width,
  parameter int FRAC_WIDTH = c_def_frac_width
) (
  input  logic signed [IN_W-1:0]                 din,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] dout,
  output logic                                   sat
);

  localparam int c_out_w = INT_WIDTH + FRAC_WIDTH;

  // The value fits exactly when every bit from the output sign bit upward
  // agrees with the input sign bit.
  logic [IN_W-c_out_w:0] w_hi;
  logic                  w_fits;

  assign w_hi   = din[IN_W-1:c_out_w-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  // Pass through when representable, otherwise pin to the nearest rail.
  always_comb begin
    sat  = ~w_fits;
    dout = din[c_out_w-1:0];
    if (!w_fits) begin
      dout = din[IN_W-1] ? {1'b1, {(c_out_w-1){1'b0}}}
                         : {1'b0, {(c_out_w-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Streaming dot product of N_INPUTS signed Q-format beats plus
//               a bias, saturated back to the input format. One result pulse
//               per vector, three cycles after the last beat is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac
  import accel_pkg::*;
#(
  parameter int INT_WIDTH  = c_def_int_width,
  parameter int FRAC_WIDTH = c_def_frac_width,
  parameter int N_INPUTS   = c_def_n_inputs
) (
  input  logic        clk,
  input  logic        rst_n,
  neuron_mac_if.slave bus
);

  localparam int c_dw    = INT_WIDTH + FRAC_WIDTH;
  localparam int c_pw    = 2 * c_dw;
  localparam int c_acc_w = acc_width(INT_WIDTH, FRAC_WIDTH, N_INPUTS);
  localparam int c_cnt_w = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N_INPUTS - 1);

  mac_state_e                r_state;
  mac_state_e                w_state_nxt;
  logic [c_cnt_w-1:0]        r_cnt;
  logic signed [c_pw-1:0]    r_prod;
  logic                      r_prod_vld;
  logic signed [c_acc_w-1:0] r_acc;
  logic signed [c_dw-1:0]    r_bias;
  logic                      r_out_valid;
  logic signed [c_dw-1:0]    r_sum;
  logic                      r_sat;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_first;
  logic signed [c_dw-1:0]    w_data;
  logic signed [c_dw-1:0]    w_weight;
  logic signed [c_pw-1:0]    w_prod;
  logic signed [c_acc_w-1:0] w_prod_ext;
  logic signed [c_acc_w-1:0] w_bias_ext;
  logic signed [c_acc_w-1:0] w_sum;
  logic signed [c_dw-1:0]    w_sat_dout;
  logic                      w_sat_flag;

  // Ready is held low while reset is asserted so nothing is taken then.
  assign w_ready  = rst_n && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
  assign w_accept = bus.in_valid && w_ready;
  assign w_first  = w_accept && (r_state == ST_IDLE);

  assign w_data     = bus.data_in;
  assign w_weight   = bus.weight_in;
  assign w_prod     = c_pw'(w_data) * c_pw'(w_weight);
  // Arithmetic shift gives floor rounding; the dropped top bits are pure
  // sign extension because a shifted product always fits in c_acc_w.
  assign w_prod_ext = c_acc_w'(r_prod >>> FRAC_WIDTH);
  assign w_bias_ext = c_acc_w'(r_bias);
  assign w_sum      = r_acc + w_bias_ext;

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_out   = r_sum;
  assign bus.sat       = r_sat;

  // Next-state decode for the beat / drain / bias sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (N_INPUTS == 1) ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (w_accept && (r_cnt == c_last)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_BIAS;
      ST_BIAS:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Beat index within the vector; parks on the last index until BIAS clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (r_state == ST_BIAS)         r_cnt <= '0;
    else if (w_accept && r_cnt != c_last) r_cnt <= r_cnt + c_cnt_w'(1);
  end

  // One-cycle product pipeline; the valid flag marks a product to fold in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= w_accept;
      if (w_accept) r_prod <= w_prod;
    end
  end

  // Accumulator: restarted and bias captured by the first beat of a vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_bias <= '0;
    end else if (w_first) begin
      r_acc  <= '0;
      r_bias <= bus.bias;
    end else if (r_prod_vld) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  fx_saturate #(
    .IN_W       (c_acc_w),
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_sat (
    .din  (w_sum),
    .dout (w_sat_dout),
    .sat  (w_sat_flag)
  );

  // Result register: loaded at the end of BIAS, held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= (r_state == ST_BIAS);
      if (r_state == ST_BIAS) begin
        r_sum <= w_sat_dout;
        r_sat <= w_sat_flag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Self-checking bench for neuron_mac (Q16.16, 8 beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

  typedef logic [31:0] word_t;
  typedef word_t vec_t [8];

  typedef struct {
    word_t data;
    word_t weight;
    word_t bias;
    word_t exp_sum;
    logic  exp_sat;
  } vect_t;

  typedef struct {
    word_t sum;
    logic  sat;
    int    lat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  neuron_mac_if #(.DATA_W(32)) bus ();

  neuron_mac #(
    .INT_WIDTH  (16),
    .FRAC_WIDTH (16),
    .N_INPUTS   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   neg_cnt = 0;
  int   last_acc = 0;
  int   n_acc = 0;
  int   n_b2b = 0;
  logic prev_ov = 1'b0;
  res_t res_q [$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Observe accepted beats and result pulses on the falling edge.
  always @(negedge clk) begin
    neg_cnt++;
    if (bus.out_valid) begin
      res_q.push_back('{bus.sum_out, bus.sat, neg_cnt - last_acc});
      check("out_valid_single_cycle", {63'd0, prev_ov}, 64'd0);
    end
    if (bus.in_valid && bus.in_ready) begin
      last_acc = neg_cnt;
      n_acc++;
      if (bus.out_valid) n_b2b++;
    end
    prev_ov = bus.out_valid;
  end

  // Reference: exact sum of floored products plus bias, clamped to Q16.16.
  function automatic logic [32:0] ref_mac(input vec_t d, input vec_t w, input word_t b);
    longint s;
    longint p;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      p = longint'($signed(d[i])) * longint'($signed(w[i]));
      s += (p >>> 16);
    end
    s += longint'($signed(b));
    if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  // Offer n beats (with random gaps), optionally keep in_valid high with junk
  // afterwards and count how long in_ready stays low.
  task automatic drive_vec(input vec_t d, input vec_t w, input word_t b, input int n,
                           input int gap_pct, input bit hold, output int low_cycles);
    int  guard;
    bit  done;
    low_cycles = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        bus.in_valid  = ($urandom_range(0, 99) >= gap_pct);
        bus.data_in   = d[i];
        bus.weight_in = w[i];
        bus.bias      = (i == 0) ? b : word_t'($urandom);
        @(negedge clk);
        done = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!done) check("beat_accept_timeout", 64'd0, 64'd1);
    end
    if (hold) begin
      bus.in_valid  = 1'b1;
      bus.data_in   = word_t'($urandom);
      bus.weight_in = word_t'($urandom);
      guard = 0;
      while (!bus.in_ready && guard < 10) begin
        low_cycles++;
        guard++;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output res_t r);
    bit ok;
    ok = 1'b0;
    r  = '{32'h0, 1'b0, 0};
    for (int k = 0; k < 60 && !ok; k++) begin
      if (res_q.size() > 0) begin
        r  = res_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("result_timeout", 64'd0, 64'd1);
  endtask

  function automatic vec_t splat(input word_t v);
    vec_t x;
    for (int i = 0; i < 8; i++) x[i] = v;
    return x;
  endfunction

  function automatic word_t rand_word(input int mode);
    case (mode)
      0:       return word_t'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
      1:       return word_t'($urandom);
      default: return word_t'(int'($urandom_range(0, 1 << 25)) - (1 << 24));
    endcase
  endfunction

  vect_t tbl [8];
  res_t  r;
  int    low;
  int    acc0;
  int    b2b0;
  vec_t  rd;
  vec_t  rw;
  word_t rb;
  logic [32:0] exp;

  initial begin
    tbl[0] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'h0004_0000, 1'b0};
    tbl[1] = '{32'hFFFF_0000, 32'h0001_0000, 32'h0000_8000, 32'hFFF8_8000, 1'b0};
    tbl[2] = '{32'h0064_0000, 32'h0064_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    tbl[3] = '{32'hFF9C_0000, 32'h0064_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[4] = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFF8, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h1234_5678, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    tbl[7] = '{32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.weight_in = '0;
    bus.bias      = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_sum_out",   {32'd0, bus.sum_out},   64'd0);
    check("rst_sat",       {63'd0, bus.sat},       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    // Directed vectors, no gaps: value, flag, latency and hold.
    for (int t = 0; t < 8; t++) begin
      drive_vec(splat(tbl[t].data), splat(tbl[t].weight), tbl[t].bias, 8, 0, 1'b0, low);
      get_result(r);
      check($sformatf("tbl%0d_sum", t), {32'd0, r.sum}, {32'd0, tbl[t].exp_sum});
      check($sformatf("tbl%0d_sat", t), {63'd0, r.sat}, {63'd0, tbl[t].exp_sat});
      check($sformatf("tbl%0d_lat", t), 64'(r.lat), 64'd3);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_hold", t), {32'd0, bus.sum_out}, {32'd0, tbl[t].exp_sum});
    end

    // Gaps plus in_valid held through DRAIN/BIAS.
    acc0 = n_acc;
    drive_vec(splat(32'h0001_0000), splat(32'h0000_8000), 32'h0, 8, 40, 1'b1, low);
    get_result(r);
    check("gap_sum", {32'd0, r.sum}, 64'h0004_0000);
    check("gap_sat", {63'd0, r.sat}, 64'd0);
    check("gap_ready_low_cycles", 64'(low), 64'd2);
    check("gap_beats_accepted", 64'(n_acc - acc0), 64'd8);

    // Reset after three beats discards the partial vector.
    drive_vec(splat(32'h0001_0000), splat(32'h0000_8000), 32'h0, 3, 0, 1'b0, low);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sum_out",   {32'd0, bus.sum_out},   64'd0);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_vec(splat(32'h0001_0000), splat(32'h0000_8000), 32'h0, 8, 0, 1'b0, low);
    get_result(r);
    check("midrst_result", {32'd0, r.sum}, 64'h0004_0000);
    repeat (15) @(negedge clk);
    check("midrst_single_pulse", 64'(res_q.size()), 64'd0);

    // Back-to-back: first beat of B is offered during A's out_valid cycle.
    b2b0 = n_b2b;
    drive_vec(splat(32'h0001_0000), splat(32'h0000_8000), 32'h0, 8, 0, 1'b0, low);
    drive_vec(splat(32'hFFFF_0000), splat(32'h0001_0000), 32'h0000_8000, 8, 0, 1'b0, low);
    get_result(r);
    check("b2b_first",  {32'd0, r.sum}, 64'h0004_0000);
    get_result(r);
    check("b2b_second", {32'd0, r.sum}, 64'hFFF8_8000);
    check("b2b_overlap", 64'(n_b2b - b2b0), 64'd1);

    // Randomized vectors against the reference model.
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < 8; i++) begin
        rd[i] = rand_word(v % 3);
        rw[i] = rand_word(v % 3);
      end
      rb  = rand_word(v % 3);
      exp = ref_mac(rd, rw, rb);
      drive_vec(rd, rw, rb, 8, 25, ($urandom_range(0, 1) == 1), low);
      get_result(r);
      check($sformatf("rnd%0d_sum", v), {32'd0, r.sum}, {32'd0, exp[31:0]});
      check($sformatf("rnd%0d_sat", v), {63'd0, r.sat}, {63'd0, exp[32]});
      check($sformatf("rnd%0d_lat", v), 64'(r.lat), 64'd3);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
